hood_key_conditioner: RTL

Front-end key conditioner for the range-hood controller. Synchronises and debounces the six raw panel buttons and maintains the `power_status` level. Delivers exactly-one-cycle, mutually exclusive command strobes (`menu`, `speed1`, `speed2`, `speed3`, `clean`) to the hood state machine. It is the producing end of that controller's command inputs and sits between the board pins and the mode/state logic.

---
 rtl/hood_pkg.sv | 39 +++
 rtl/key_debounce.sv | 51 +++++
 rtl/hood_key_conditioner.sv | 127 ++++++++++++
 3 files changed

// File: rtl/hood_pkg.sv
// hood_pkg: key indices, default timing constants and the press-event priority
// arbiter shared by the key conditioner and the hood controller.
package hood_pkg;

  localparam int KEY_POWER  = 0;
  localparam int KEY_MENU   = 1;
  localparam int KEY_SPEED1 = 2;
  localparam int KEY_SPEED2 = 3;
  localparam int KEY_SPEED3 = 4;
  localparam int KEY_CLEAN  = 5;
  localparam int NUM_KEYS   = 6;

  localparam int DEFAULT_DEBOUNCE_TIME   = 1_000_000;
  localparam int DEFAULT_LONG_PRESS_TIME = 300_000_000;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_POWER  = 3'd1,
    CMD_MENU   = 3'd2,
    CMD_CLEAN  = 3'd3,
    CMD_SPEED3 = 3'd4,
    CMD_SPEED2 = 3'd5,
    CMD_SPEED1 = 3'd6
  } cmd_e;

  // Fixed priority: losers in the same cycle are simply dropped.
  function automatic cmd_e arbitrate(input logic [NUM_KEYS-1:0] press);
    cmd_e cmd;
    if (press[KEY_POWER])       cmd = CMD_POWER;
    else if (press[KEY_MENU])   cmd = CMD_MENU;
    else if (press[KEY_CLEAN])  cmd = CMD_CLEAN;
    else if (press[KEY_SPEED3]) cmd = CMD_SPEED3;
    else if (press[KEY_SPEED2]) cmd = CMD_SPEED2;
    else if (press[KEY_SPEED1]) cmd = CMD_SPEED1;
    else                        cmd = CMD_NONE;
    return cmd;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser plus all-or-nothing debounce for one raw key;
// emits the stable level and a one-cycle pulse on each accepted 0->1 change.
module key_debounce
  import hood_pkg::*;
#(
  parameter int DEBOUNCE_TIME = DEFAULT_DEBOUNCE_TIME
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);

  localparam int CNT_W = $clog2(DEBOUNCE_TIME + 1);
  localparam logic [CNT_W-1:0] CNT_FLIP = CNT_W'(DEBOUNCE_TIME);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;

  // Any bounce back to the stable value discards the accumulated count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt >= CNT_FLIP) begin
        r_stable <= r_sync2;
        r_press  <= r_sync2;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_level = r_stable;
  assign o_press = r_press;

endmodule

// File: rtl/hood_key_conditioner.sv
// hood_key_conditioner: debounces the six panel keys, arbitrates press events and
// drives power_status plus one-cycle command strobes. Macro: HOOD_LONG_PRESS_POWER_OFF_EN.
module hood_key_conditioner
  import hood_pkg::*;
#(
  parameter int DEBOUNCE_TIME   = DEFAULT_DEBOUNCE_TIME,
  parameter int LONG_PRESS_TIME = DEFAULT_LONG_PRESS_TIME
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                btn_power,
  input  logic                btn_menu,
  input  logic                btn_speed1,
  input  logic                btn_speed2,
  input  logic                btn_speed3,
  input  logic                btn_clean,
  output logic                power_status,
  output logic                menu,
  output logic                speed1,
  output logic                speed2,
  output logic                speed3,
  output logic                clean,
  output logic [NUM_KEYS-1:0] key_level
);

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_level;
  logic [NUM_KEYS-1:0] w_press;
  cmd_e                w_cmd;
  logic                w_power_next;
  logic                r_power;
  logic                r_menu;
  logic                r_speed1;
  logic                r_speed2;
  logic                r_speed3;
  logic                r_clean;

  if (DEBOUNCE_TIME < 1 || LONG_PRESS_TIME < 1) begin : g_param_check
    $error("hood_key_conditioner: timing parameters must be positive");
  end

  assign w_raw = {btn_clean, btn_speed3, btn_speed2, btn_speed1, btn_menu, btn_power};

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DEBOUNCE_TIME(DEBOUNCE_TIME)
    ) u_key_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (w_raw[g]),
      .o_level(w_level[g]),
      .o_press(w_press[g])
    );
  end

  assign w_cmd = arbitrate(w_press);

`ifdef HOOD_LONG_PRESS_POWER_OFF_EN
  localparam int HOLD_W = $clog2(LONG_PRESS_TIME + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(LONG_PRESS_TIME);

  logic [HOLD_W-1:0] r_hold;
  logic              r_hold_en;

  // The hold timer runs only for a press that began while already powered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold    <= '0;
      r_hold_en <= 1'b0;
    end else if (!w_level[KEY_POWER]) begin
      r_hold    <= '0;
      r_hold_en <= 1'b0;
    end else if ((w_press[KEY_POWER] && r_power) || r_hold_en) begin
      r_hold_en <= 1'b1;
      if (r_hold != HOLD_MAX) r_hold <= r_hold + HOLD_W'(1);
    end
  end

  always_comb begin
    w_power_next = r_power;
    if (w_cmd == CMD_POWER && !r_power) begin
      w_power_next = 1'b1;
    end else if (r_hold_en && r_hold == HOLD_MAX) begin
      w_power_next = 1'b0;
    end else begin
      w_power_next = r_power;
    end
  end
`else
  always_comb begin
    w_power_next = r_power;
    if (w_cmd == CMD_POWER) begin
      w_power_next = ~r_power;
    end else begin
      w_power_next = r_power;
    end
  end
`endif

  // Strobes are gated by the power level held before this cycle's update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_power  <= 1'b0;
      r_menu   <= 1'b0;
      r_speed1 <= 1'b0;
      r_speed2 <= 1'b0;
      r_speed3 <= 1'b0;
      r_clean  <= 1'b0;
    end else begin
      r_power  <= w_power_next;
      r_menu   <= r_power && (w_cmd == CMD_MENU);
      r_speed1 <= r_power && (w_cmd == CMD_SPEED1);
      r_speed2 <= r_power && (w_cmd == CMD_SPEED2);
      r_speed3 <= r_power && (w_cmd == CMD_SPEED3);
      r_clean  <= r_power && (w_cmd == CMD_CLEAN);
    end
  end

  assign power_status = r_power;
  assign menu         = r_menu;
  assign speed1       = r_speed1;
  assign speed2       = r_speed2;
  assign speed3       = r_speed3;
  assign clean        = r_clean;
  assign key_level    = w_level;

endmodule
